// File: rtl/page_pkg.sv
// page_pkg: shared widths, status codes, FSM states and fault rule for the page lookup controller
package page_pkg;
  localparam int DEF_IDX_W   = 8;
  localparam int DEF_REF_W   = 16;
  localparam int DEF_OFF_W   = 8;
  localparam int DEF_ENTRIES = 4;
  localparam int DEF_TMO_CYC = 16;
  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_RW  = 2'b01;
  localparam logic [1:0] ST_RO  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;
  typedef enum logic [1:0] {IDLE, LOOKUP, DIR_WAIT, RESP} state_e;
  function automatic logic pinv_f(input logic [1:0] st, input logic rw);
    return (st == ST_INV) || (st == ST_ERR) || (st == ST_RO && rw);
  endfunction
endpackage

// File: rtl/page_lookup_ctrl_if.sv
// page_lookup_ctrl_if: CPU request/response and page directory signals of the lookup controller
interface page_lookup_ctrl_if
  import page_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int REF_W = DEF_REF_W,
  parameter int OFF_W = DEF_OFF_W
);
  logic                   REQ_V;
  logic                   REQ_RDY;
  logic [IDX_W+OFF_W-1:0] REQ_VA;
  logic                   RW;
  logic                   RSP_V;
  logic [REF_W+OFF_W-1:0] RSP_PA;
  logic                   PINV;
  logic [1:0]             STATUS;
  logic                   SINT;
  logic                   PLCK;
  logic                   DIR_REQ;
  logic [IDX_W-1:0]       DIR_IDX;
  logic                   DIR_ACK;
  logic [REF_W-1:0]       DIR_REF;
  logic [1:0]             DIR_STATUS;
  modport master (
    output REQ_V, REQ_VA, RW, SINT, PLCK, DIR_ACK, DIR_REF, DIR_STATUS,
    input  REQ_RDY, RSP_V, RSP_PA, PINV, STATUS, DIR_REQ, DIR_IDX
  );
  modport slave (
    input  REQ_V, REQ_VA, RW, SINT, PLCK, DIR_ACK, DIR_REF, DIR_STATUS,
    output REQ_RDY, RSP_V, RSP_PA, PINV, STATUS, DIR_REQ, DIR_IDX
  );
endinterface

// File: rtl/page_tb_cam.sv
// page_tb_cam: fully-associative translation buffer with round-robin fill and flush
module page_tb_cam
  import page_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int REF_W   = DEF_REF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [REF_W-1:0] wr_ref_i,
  input  logic [1:0]       wr_st_i,
  input  logic [IDX_W-1:0] lk_idx_i,
  output logic             hit_o,
  output logic [REF_W-1:0] ref_o,
  output logic [1:0]       st_o
);
  localparam int PW = $clog2(ENTRIES);
  logic [ENTRIES-1:0] vld_q;
  logic [PW-1:0]      ptr_q;
  logic [IDX_W-1:0]   idx_q [ENTRIES];
  logic [REF_W-1:0]   ref_q [ENTRIES];
  logic [1:0]         st_q  [ENTRIES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else if (wr_en_i) begin
      vld_q[ptr_q] <= 1'b1;
      ptr_q        <= ptr_q + PW'(1);
    end
  end
  // payload needs no reset: it is only visible through a set valid bit
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      idx_q[ptr_q] <= wr_idx_i;
      ref_q[ptr_q] <= wr_ref_i;
      st_q[ptr_q]  <= wr_st_i;
    end
  end
  always_comb begin
    hit_o = 1'b0;
    ref_o = '0;
    st_o  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld_q[i] && idx_q[i] == lk_idx_i) begin
        hit_o = 1'b1;
        ref_o = ref_q[i];
        st_o  = st_q[i];
      end
    end
  end
endmodule

// File: rtl/page_lookup_ctrl.sv
// page_lookup_ctrl: translates {index,offset} to {ref,offset} via a TB, fetching misses from the page directory
module page_lookup_ctrl
  import page_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int REF_W   = DEF_REF_W,
  parameter int OFF_W   = DEF_OFF_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input logic               SCLK,
  input logic               SRST,
  page_lookup_ctrl_if.slave bus
);
  localparam int TW = $clog2(TMO_CYC + 1);
  state_e                 state_q, state_d;
  logic [IDX_W+OFF_W-1:0] va_q, va_d;
  logic                   rw_q, rw_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   disc_q, disc_d;
  logic [REF_W-1:0]       ref_q, ref_d;
  logic [1:0]             st_q, st_d;
  logic                   wr_en, hit, rsp_v, pinv;
  logic [REF_W-1:0]       cam_ref;
  logic [1:0]             cam_st;
  logic [IDX_W-1:0]       idx;
  assign idx = va_q[IDX_W+OFF_W-1:OFF_W];
  page_tb_cam #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .REF_W(REF_W)) u_cam (
    .clk      (SCLK),
    .rst_n    (SRST),
    .flush_i  (bus.SINT),
    .wr_en_i  (wr_en),
    .wr_idx_i (idx),
    .wr_ref_i (bus.DIR_REF),
    .wr_st_i  (bus.DIR_STATUS),
    .lk_idx_i (idx),
    .hit_o    (hit),
    .ref_o    (cam_ref),
    .st_o     (cam_st)
  );
  always_ff @(posedge SCLK or negedge SRST) begin
    if (!SRST) begin
      state_q <= IDLE;
      va_q    <= '0;
      rw_q    <= 1'b0;
      tmo_q   <= '0;
      disc_q  <= 1'b0;
      ref_q   <= '0;
      st_q    <= ST_INV;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      rw_q    <= rw_d;
      tmo_q   <= tmo_d;
      disc_q  <= disc_d;
      ref_q   <= ref_d;
      st_q    <= st_d;
    end
  end
  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    rw_d    = rw_q;
    tmo_d   = tmo_q;
    disc_d  = disc_q;
    ref_d   = ref_q;
    st_d    = st_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.REQ_V && bus.REQ_RDY) begin
        state_d = LOOKUP;
        va_d    = bus.REQ_VA;
        rw_d    = bus.RW;
      end
      LOOKUP: if (hit && !bus.SINT) begin
        state_d = RESP;
        ref_d   = cam_ref;
        st_d    = cam_st;
      end else begin
        state_d = DIR_WAIT;
        tmo_d   = '0;
        disc_d  = 1'b0;
      end
      DIR_WAIT: begin
        // a flush seen anywhere in the wait cancels the fill but not the response
        disc_d = disc_q | bus.SINT;
        if (bus.DIR_ACK) begin
          state_d = RESP;
          ref_d   = bus.DIR_REF;
          st_d    = bus.DIR_STATUS;
          wr_en   = (bus.DIR_STATUS == ST_RW || bus.DIR_STATUS == ST_RO) && !disc_q && !bus.SINT;
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          state_d = RESP;
          ref_d   = '0;
          st_d    = ST_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign rsp_v       = state_q == RESP;
  assign pinv        = rsp_v && pinv_f(st_q, rw_q);
  assign bus.RSP_V   = rsp_v;
  assign bus.PINV    = pinv;
  assign bus.STATUS  = rsp_v ? st_q : '0;
  assign bus.RSP_PA  = (rsp_v && !pinv) ? {ref_q, va_q[OFF_W-1:0]} : '0;
  assign bus.DIR_REQ = state_q == DIR_WAIT;
  assign bus.DIR_IDX = idx;
  assign bus.REQ_RDY = SRST && state_q == IDLE && !bus.PLCK && !bus.SINT;
endmodule
